// File: rtl/acc_req_issuer.sv
// Per-accumulator addend queues between commit and the shared FP accumulators.
// Each accumulator drains its own FIFO in push order, independent of the others.
module acc_req_issuer #(
    parameter int N_ACC = 3,
    parameter int DEPTH = 4,
    localparam int AW = (N_ACC > 1) ? $clog2(N_ACC) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  logic [AW-1:0]         push_acc,
    input  logic [31:0]           push_data,
    output logic [N_ACC-1:0]      push_ready,
    output logic [N_ACC-1:0]      acc_req_valid,
    input  logic [N_ACC-1:0]      acc_req_ready,
    output logic [N_ACC*32-1:0]   acc_data,
    output logic                  no_acc_pending
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [N_ACC-1:0] busy;

    for (genvar i = 0; i < N_ACC; i++) begin : g_q
        logic [31:0]   mem [DEPTH];
        logic [PW-1:0] rd_ptr;
        logic [PW-1:0] wr_ptr;
        logic [CW-1:0] count;
        logic          not_full;
        logic          not_empty;
        logic          enq;
        logic          deq;

        assign not_full  = count < CW'(DEPTH);
        assign not_empty = count != '0;
        // Out-of-range push_acc never matches any queue index.
        assign enq = push && (push_acc == AW'(i)) && not_full;
        assign deq = not_empty && acc_req_ready[i];

        always_ff @(posedge clk) begin
            if (reset) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
                count  <= '0;
            end else begin
                if (enq) wr_ptr <= wr_ptr + 1'b1;
                if (deq) rd_ptr <= rd_ptr + 1'b1;
                if (enq && !deq) count <= count + 1'b1;
                else if (deq && !enq) count <= count - 1'b1;
            end
        end

        always_ff @(posedge clk) begin
            if (enq && !reset) mem[wr_ptr] <= push_data;
        end

        assign push_ready[i]         = not_full;
        assign acc_req_valid[i]      = not_empty;
        assign busy[i]               = not_empty;
        assign acc_data[i*32 +: 32]  = mem[rd_ptr];
    end

    assign no_acc_pending = ~|busy;

endmodule

// File: tb/tb_acc_req_issuer.sv
// Directed plus randomized checks of acc_req_issuer against a queue model.
// Model holds one SystemVerilog queue per accumulator.
module tb_acc_req_issuer;

    localparam int N = 3;
    localparam int D = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          push;
    logic [1:0]    push_acc;
    logic [31:0]   push_data;
    logic [N-1:0]  push_ready;
    logic [N-1:0]  acc_req_valid;
    logic [N-1:0]  acc_req_ready;
    logic [N*32-1:0] acc_data;
    logic          no_acc_pending;

    int checks = 0;
    int passes = 0;

    logic [31:0] q [N][$];

    always #5 clk = ~clk;

    acc_req_issuer #(.N_ACC(N), .DEPTH(D)) dut (
        .clk(clk),
        .reset(reset),
        .push(push),
        .push_acc(push_acc),
        .push_data(push_data),
        .push_ready(push_ready),
        .acc_req_valid(acc_req_valid),
        .acc_req_ready(acc_req_ready),
        .acc_data(acc_data),
        .no_acc_pending(no_acc_pending)
    );

    task automatic check_outputs(input string tag);
        logic [N-1:0] ev;
        logic [N-1:0] er;
        logic         ep;
        logic [31:0]  got;
        ep = 1'b1;
        for (int i = 0; i < N; i++) begin
            ev[i] = q[i].size() > 0;
            er[i] = q[i].size() < D;
            if (q[i].size() > 0) ep = 1'b0;
        end
        checks++;
        assert (acc_req_valid === ev) passes++;
        else $error("FAIL %s valid got %b exp %b", tag, acc_req_valid, ev);
        checks++;
        assert (push_ready === er) passes++;
        else $error("FAIL %s push_ready got %b exp %b", tag, push_ready, er);
        checks++;
        assert (no_acc_pending === ep) passes++;
        else $error("FAIL %s no_pending got %b exp %b", tag, no_acc_pending, ep);
        for (int i = 0; i < N; i++) begin
            if (q[i].size() > 0) begin
                got = acc_data[i*32 +: 32];
                checks++;
                assert (got === q[i][0]) passes++;
                else $error("FAIL %s data[%0d] got %h exp %h", tag, i, got, q[i][0]);
            end
        end
    endtask

    task automatic cycle(input string tag, input logic rst, input logic p,
                         input logic [1:0] a, input logic [31:0] d,
                         input logic [N-1:0] rdy);
        int sz [N];
        reset = rst;
        push = p;
        push_acc = a;
        push_data = d;
        acc_req_ready = rdy;
        check_outputs(tag);
        for (int i = 0; i < N; i++) sz[i] = q[i].size();
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < N; i++) q[i].delete();
        end else begin
            for (int i = 0; i < N; i++)
                if (sz[i] > 0 && rdy[i]) void'(q[i].pop_front());
            if (p && int'(a) < N && sz[a] < D) q[a].push_back(d);
        end
        #1;
    endtask

    task automatic idle(input string tag, input logic [N-1:0] rdy, input int n);
        for (int k = 0; k < n; k++) cycle(tag, 1'b0, 1'b0, 2'd0, 32'h0, rdy);
    endtask

    initial begin
        reset = 1'b1;
        push = 1'b0;
        push_acc = '0;
        push_data = '0;
        acc_req_ready = '0;
        @(posedge clk);
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) q[i].delete();
        idle("reset", 3'b000, 1);

        cycle("single_push", 1'b0, 1'b1, 2'd1, 32'h3F800000, 3'b111);
        idle("single_issue", 3'b111, 2);

        cycle("fill1", 1'b0, 1'b1, 2'd0, 32'h3F800000, 3'b000);
        cycle("fill2", 1'b0, 1'b1, 2'd0, 32'h40000000, 3'b000);
        cycle("fill3", 1'b0, 1'b1, 2'd0, 32'h40400000, 3'b000);
        cycle("fill4", 1'b0, 1'b1, 2'd0, 32'h40800000, 3'b000);
        cycle("full_push", 1'b0, 1'b1, 2'd0, 32'h40A00000, 3'b000);
        cycle("full_deq_push", 1'b0, 1'b1, 2'd0, 32'h40C00000, 3'b001);
        cycle("push_after", 1'b0, 1'b1, 2'd0, 32'h40C00000, 3'b001);
        idle("drain0", 3'b111, 5);

        cycle("hol_a", 1'b0, 1'b1, 2'd0, 32'h11111111, 3'b000);
        cycle("hol_b", 1'b0, 1'b1, 2'd0, 32'h22222222, 3'b000);
        cycle("hol_c", 1'b0, 1'b1, 2'd2, 32'h40400000, 3'b100);
        idle("hol_issue", 3'b100, 2);
        idle("hol_drain", 3'b111, 3);

        cycle("wrap_a", 1'b0, 1'b1, 2'd1, 32'hA0000000, 3'b000);
        cycle("wrap_b", 1'b0, 1'b1, 2'd1, 32'hA0000001, 3'b000);
        for (int k = 0; k < 8; k++)
            cycle("wrap_flow", 1'b0, 1'b1, 2'd1, 32'hB0000000 + k, 3'b010);
        idle("wrap_drain", 3'b111, 3);

        cycle("bad_acc", 1'b0, 1'b1, 2'd3, 32'hBAD0BAD0, 3'b111);
        idle("bad_acc_chk", 3'b111, 1);

        cycle("pre_rst0", 1'b0, 1'b1, 2'd0, 32'h00000010, 3'b000);
        cycle("pre_rst1", 1'b0, 1'b1, 2'd1, 32'h00000011, 3'b000);
        cycle("pre_rst2", 1'b0, 1'b1, 2'd2, 32'h00000012, 3'b000);
        cycle("pre_rst3", 1'b0, 1'b1, 2'd0, 32'h00000013, 3'b000);
        cycle("mid_rst", 1'b1, 1'b1, 2'd0, 32'hDEADBEEF, 3'b000);
        idle("post_rst", 3'b111, 3);

        for (int k = 0; k < 400; k++) begin
            cycle("random", ($urandom_range(0, 99) == 0), $urandom_range(0, 2) != 0,
                  2'($urandom_range(0, 3)), $urandom,
                  3'($urandom_range(0, 7)));
        end
        idle("final_drain", 3'b111, D + 2);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
